// File: rtl/nes_pad_reader.sv
// nes_pad_reader: polls a NES pad's 4021 shift register and presents a registered button vector
module nes_pad_reader #(
    parameter int BIT_CYCLES  = 120,
    parameter int POLL_CYCLES = 166667
) (
    input  logic       clock_10MHz,
    input  logic       reset,
    input  logic       poll_en,
    input  logic       poll_req,
    input  logic       nes_data,
    output logic       nes_latch,
    output logic       nes_pulse,
    output logic [7:0] buttons,
    output logic       valid,
    output logic       busy
);
    localparam int SW   = $clog2(BIT_CYCLES);
    localparam int TW   = $clog2(POLL_CYCLES);
    localparam int HALF = BIT_CYCLES / 2;

    typedef enum logic [2:0] {IDLE, LATCH, PULSE_HI, PULSE_LO, DONE} state_t;

    state_t          state_q, state_d;
    logic [SW-1:0]   slot_q, slot_d;
    logic [2:0]      bit_q, bit_d;
    logic [7:0]      shift_q, shift_d;
    logic [7:0]      buttons_q, buttons_d;
    logic [TW-1:0]   timer_q, timer_d;
    logic [1:0]      sync_q, sync_d;
    logic            pend_q, pend_d;
    logic            latch_q, latch_d;
    logic            pulse_q, pulse_d;
    logic            valid_q, valid_d;
    logic            busy_q, busy_d;
    logic            wrap, start;

    // Next state, counters, sampling, and pin/strobe values registered from the next state
    always_comb begin
        state_d   = state_q;
        slot_d    = slot_q;
        bit_d     = bit_q;
        shift_d   = shift_q;
        buttons_d = buttons_q;
        start     = 1'b0;
        sync_d    = {sync_q[0], nes_data};
        wrap      = poll_en && (timer_q == TW'(POLL_CYCLES - 1));
        timer_d   = (!poll_en || wrap) ? '0 : timer_q + TW'(1);
        case (state_q)
            IDLE: begin
                if (pend_q || wrap) begin
                    state_d = LATCH;
                    slot_d  = '0;
                    start   = 1'b1;
                end
            end
            LATCH: begin
                if (slot_q == SW'(BIT_CYCLES - 1)) begin
                    shift_d[0] = sync_q[1];
                    bit_d      = 3'd1;
                    slot_d     = '0;
                    state_d    = PULSE_HI;
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            PULSE_HI: begin
                slot_d  = (slot_q == SW'(HALF - 1)) ? '0 : slot_q + SW'(1);
                state_d = (slot_q == SW'(HALF - 1)) ? PULSE_LO : PULSE_HI;
            end
            PULSE_LO: begin
                if (slot_q == SW'(BIT_CYCLES - HALF - 1)) begin
                    shift_d[bit_q] = sync_q[1];
                    slot_d         = '0;
                    if (bit_q == 3'd7) begin
                        state_d   = DONE;
                        buttons_d = ~shift_d;
                    end else begin
                        bit_d   = bit_q + 3'd1;
                        state_d = PULSE_HI;
                    end
                end else begin
                    slot_d = slot_q + SW'(1);
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        pend_d  = start ? 1'b0 : (pend_q | poll_req | wrap);
        latch_d = (state_d == LATCH);
        pulse_d = (state_d == PULSE_HI);
        valid_d = (state_d == DONE);
        busy_d  = (state_d != IDLE);
    end

    // State and output registers; reset aborts any frame and releases the pad pins
    always_ff @(posedge clock_10MHz or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            slot_q    <= '0;
            bit_q     <= '0;
            shift_q   <= '0;
            buttons_q <= '0;
            timer_q   <= '0;
            sync_q    <= 2'b11;
            pend_q    <= 1'b0;
            latch_q   <= 1'b0;
            pulse_q   <= 1'b0;
            valid_q   <= 1'b0;
            busy_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            slot_q    <= slot_d;
            bit_q     <= bit_d;
            shift_q   <= shift_d;
            buttons_q <= buttons_d;
            timer_q   <= timer_d;
            sync_q    <= sync_d;
            pend_q    <= pend_d;
            latch_q   <= latch_d;
            pulse_q   <= pulse_d;
            valid_q   <= valid_d;
            busy_q    <= busy_d;
        end
    end

    assign nes_latch = latch_q;
    assign nes_pulse = pulse_q;
    assign buttons   = buttons_q;
    assign valid     = valid_q;
    assign busy      = busy_q;
endmodule

// File: tb/tb_nes_pad_reader.sv
// tb_nes_pad_reader: scoreboard bench with a behavioural 4021 pad model
module tb_nes_pad_reader;
    logic       clk = 1'b0;
    logic       reset, poll_en, poll_req, nes_data;
    logic       nes_latch, nes_pulse, valid, busy;
    logic [7:0] buttons;

    nes_pad_reader #(.BIT_CYCLES(8), .POLL_CYCLES(400)) dut (
        .clock_10MHz(clk), .reset(reset), .poll_en(poll_en), .poll_req(poll_req),
        .nes_data(nes_data), .nes_latch(nes_latch), .nes_pulse(nes_pulse),
        .buttons(buttons), .valid(valid), .busy(busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s: got %0d want %0d", name, act, exp);
        end
    endtask

    // Pad: 1 = pressed. The 4021 loads the inverted pad while latch is high and
    // shifts toward bit 0 (filling with released level) on each pulse rising edge.
    logic [7:0] pad = 8'h00;
    logic       hold0 = 1'b0;
    logic [7:0] sr = 8'hFF;
    always @(posedge nes_latch or posedge nes_pulse)
        sr <= nes_latch ? ~pad : {1'b1, sr[7:1]};
    assign nes_data = hold0 ? 1'b0 : sr[0];

    // Monitor: expected vector pushed when the pad is latched, popped on valid
    logic [7:0] q[$];
    int cyc = 0, nvalid = 0, last_valid = 0, valid_gap = 0;
    int pulses = 0, latch_len = 0, busy_len = 0, hi_run = 0;
    logic overlap = 0, hi_bad = 0, prev_latch = 0, prev_pulse = 0;
    always @(negedge clk) begin
        cyc++;
        if (reset) begin
            q.delete();
            prev_latch = 0;
            prev_pulse = 0;
        end else begin
            if (nes_latch && !prev_latch) begin
                q.push_back(hold0 ? 8'hFF : pad);
                pulses = 0; latch_len = 0; busy_len = 0; overlap = 0; hi_bad = 0;
            end
            if (nes_latch) latch_len++;
            if (busy) busy_len++;
            if (nes_latch && nes_pulse) overlap = 1;
            if (nes_pulse) begin
                if (!prev_pulse) pulses++;
                hi_run = prev_pulse ? hi_run + 1 : 1;
            end else if (prev_pulse && hi_run != 4) hi_bad = 1;
            if (valid) begin
                nvalid++;
                valid_gap = cyc - last_valid;
                last_valid = cyc;
                if (q.size() == 0) chk("valid_without_frame", 1, 0);
                else chk("buttons", int'(buttons), int'(q.pop_front()));
                chk("pulse_count", pulses, 7);
                chk("latch_width", latch_len, 8);
                chk("busy_width", busy_len, 65);
                chk("latch_pulse_overlap", int'(overlap), 0);
                chk("pulse_hi_width_bad", int'(hi_bad), 0);
            end
            prev_latch = nes_latch;
            prev_pulse = nes_pulse;
        end
    end

    // Issue one poll_req and return clocks until busy drops (0 on timeout)
    task automatic req_frame(output int n);
        logic seen = 0;
        @(negedge clk) poll_req = 1;
        @(negedge clk) poll_req = 0;
        n = 0;
        for (int i = 1; i <= 300; i++) begin
            @(negedge clk);
            if (busy) seen = 1;
            if (seen && !busy) begin
                n = i;
                break;
            end
        end
        if (n == 0) chk("frame_timeout", 0, 1);
    endtask

    initial begin
        int n, v, g;
        reset = 1; poll_en = 0; poll_req = 0;
        repeat (3) @(negedge clk);
        chk("rst_latch", int'(nes_latch), 0);
        chk("rst_pulse", int'(nes_pulse), 0);
        chk("rst_buttons", int'(buttons), 0);
        chk("rst_valid", int'(valid), 0);
        chk("rst_busy", int'(busy), 0);
        reset = 0;
        repeat (3) @(negedge clk);

        // A+Start via single request
        pad = 8'h09;
        v = nvalid;
        req_frame(n);
        chk("frame_len", n, 66);
        chk("single_valid", nvalid - v, 1);
        chk("buttons_a_start", int'(buttons), 8'h09);

        // Automatic polling, nothing pressed
        pad = 8'h00;
        v = nvalid;
        @(negedge clk) poll_en = 1;
        repeat (1300) @(negedge clk);
        poll_en = 0;
        chk("auto_poll_count", nvalid - v, 3);
        chk("auto_poll_gap", valid_gap, 400);
        chk("buttons_none", int'(buttons), 0);
        repeat (100) @(negedge clk);

        // All pressed (data held low), then Right only
        hold0 = 1;
        req_frame(n);
        chk("buttons_all", int'(buttons), 8'hFF);
        hold0 = 0;
        pad = 8'h80;
        req_frame(n);
        chk("buttons_right", int'(buttons), 8'h80);

        // Three requests during one frame collapse into one follow-up frame
        pad = 8'($urandom_range(1, 255));
        v = nvalid;
        @(negedge clk) poll_req = 1;
        @(negedge clk) poll_req = 0;
        for (int k = 0; k < 3; k++) begin
            repeat (10) @(negedge clk) poll_req = 0;
            poll_req = 1;
            @(negedge clk) poll_req = 0;
        end
        g = 0;
        for (int i = 0; i < 400 && nvalid - v < 2; i++) @(negedge clk);
        g = valid_gap;
        repeat (150) @(negedge clk);
        chk("collapsed_frames", nvalid - v, 2);
        chk("back_to_back_gap", g, 66);

        // Reset during the high phase of bit 4
        @(negedge clk) poll_req = 1;
        @(negedge clk) poll_req = 0;
        n = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (nes_pulse && pulses == 4) begin
                n = 1;
                break;
            end
        end
        chk("reached_bit4", n, 1);
        v = nvalid;
        reset = 1;
        @(posedge clk) #1;
        chk("abort_latch", int'(nes_latch), 0);
        chk("abort_pulse", int'(nes_pulse), 0);
        chk("abort_buttons", int'(buttons), 0);
        chk("abort_valid", int'(valid), 0);
        repeat (3) @(negedge clk);
        reset = 0;
        repeat (80) @(negedge clk);
        chk("abort_no_valid", nvalid - v, 0);
        pad = 8'h5A;
        req_frame(n);
        chk("post_reset_len", n, 66);
        chk("post_reset_buttons", int'(buttons), 8'h5A);

        // Random pad patterns
        for (int k = 0; k < 6; k++) begin
            pad = 8'($urandom);
            req_frame(n);
            chk("rand_frame_len", n, 66);
        end

        repeat (10) @(negedge clk);
        chk("scoreboard_empty", q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
